// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: definitions shared by the operand path and the ALU.
//   opsel_e : operand-B source select encoding (REG, NEG REG, IMM, NEG IMM)
package cpu_defs_pkg;

   typedef enum logic [1:0] {
      OPSEL_REG    = 2'b00,
      OPSEL_NEGREG = 2'b01,
      OPSEL_IMM    = 2'b10,
      OPSEL_NEGIMM = 2'b11
   } opsel_e;

endpackage : cpu_defs_pkg

// File: rtl/twos_comp_unit.sv
// twos_comp_unit: combinational two's-complement negation, shared with the ALU.
//   i_val [WIDTH-1:0] : value to negate
//   o_neg [WIDTH-1:0] : (~i_val)+1, truncated to WIDTH
//   o_ovf             : i_val is the most-negative value (the result equals the input)
module twos_comp_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_val,
   output logic [WIDTH-1:0] o_neg,
   output logic             o_ovf
);

   assign o_neg = (~i_val) + WIDTH'(1);
   // Only {1,0..0} maps onto itself; zero also maps to itself but is not an overflow.
   assign o_ovf = i_val[WIDTH-1] & ~(|i_val[WIDTH-2:0]);

endmodule : twos_comp_unit

// File: rtl/operand_select_pipe.sv
// operand_select_pipe: selects ALU operand B (reg / -reg / imm / -imm) and buffers the
// result with its negate-overflow flag in a DEPTH-entry FIFO with valid/ready on both sides.
//   CLK, RESETN          : rising-edge clock, asynchronous active-low reset
//   FLUSH                : synchronous clear of all buffered entries; beats push and pop
//   IN_VALID / IN_READY  : upstream request handshake
//   OPSEL                : operand source select (cpu_defs_pkg::opsel_e)
//   REGOUT2, IMMEDIATE   : candidate operands
//   OUT_VALID / OUT_READY: downstream handshake for the FIFO head
//   OPERAND, NEGOVF      : FIFO head entry
//   COUNT                : number of entries held
module operand_select_pipe
   import cpu_defs_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     CLK,
   input  logic                     RESETN,
   input  logic                     FLUSH,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [1:0]               OPSEL,
   input  logic [WIDTH-1:0]         REGOUT2,
   input  logic [WIDTH-1:0]         IMMEDIATE,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [WIDTH-1:0]         OPERAND,
   output logic                     NEGOVF,
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] w_src;
   logic             w_negate;
   logic [WIDTH-1:0] w_neg;
   logic             w_neg_ovf;
   logic [WIDTH-1:0] w_sel;
   logic             w_sel_ovf;
   logic             w_push;
   logic             w_pop;

   logic [WIDTH:0]   r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Select source and whether to negate it.
   always_comb begin
      w_src    = REGOUT2;
      w_negate = 1'b0;
      case (opsel_e'(OPSEL))
         OPSEL_REG:    begin w_src = REGOUT2;   w_negate = 1'b0; end
         OPSEL_NEGREG: begin w_src = REGOUT2;   w_negate = 1'b1; end
         OPSEL_IMM:    begin w_src = IMMEDIATE; w_negate = 1'b0; end
         OPSEL_NEGIMM: begin w_src = IMMEDIATE; w_negate = 1'b1; end
      endcase
   end

   twos_comp_unit #(.WIDTH(WIDTH)) u_neg (
      .i_val (w_src),
      .o_neg (w_neg),
      .o_ovf (w_neg_ovf)
   );

   assign w_sel     = w_negate ? w_neg : w_src;
   assign w_sel_ovf = w_negate & w_neg_ovf;

   // A full FIFO still accepts when the head leaves in the same cycle.
   assign IN_READY  = (r_count < CW'(DEPTH)) || OUT_READY;
   assign OUT_VALID = (r_count != '0);
   assign w_push    = IN_VALID && IN_READY && !FLUSH;
   assign w_pop     = OUT_VALID && OUT_READY && !FLUSH;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= {w_sel_ovf, w_sel};
      end
   end

   // Pointers are PW bits wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (FLUSH) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head is read straight from storage; when empty it shows a stale but defined entry.
   assign {NEGOVF, OPERAND} = r_mem[r_rd_ptr];
   assign COUNT             = r_count;

endmodule : operand_select_pipe

// File: tb/tb_operand_select_pipe.sv
module tb_operand_select_pipe;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 2;

   logic         CLK;
   logic         RESETN;
   logic         FLUSH;
   logic         IN_VALID;
   logic         IN_READY;
   logic [1:0]   OPSEL;
   logic [7:0]   REGOUT2;
   logic [7:0]   IMMEDIATE;
   logic         OUT_VALID;
   logic         OUT_READY;
   logic [7:0]   OPERAND;
   logic         NEGOVF;
   logic [1:0]   COUNT;

   int unsigned  n_checks;
   int unsigned  n_fail;

   operand_select_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .FLUSH     (FLUSH),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .OPSEL     (OPSEL),
      .REGOUT2   (REGOUT2),
      .IMMEDIATE (IMMEDIATE),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OPERAND   (OPERAND),
      .NEGOVF    (NEGOVF),
      .COUNT     (COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance past the next rising edge; inputs are changed and outputs sampled here.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_one(input logic [1:0] sel, input logic [7:0] r, input logic [7:0] imm);
      IN_VALID  = 1'b1;
      OPSEL     = sel;
      REGOUT2   = r;
      IMMEDIATE = imm;
   endtask

   // Stimulus tables for the mode and overflow checks.
   logic [1:0] mode_sel [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
   logic [7:0] mode_reg [6] = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h80, 8'h00};
   logic [7:0] mode_op  [6] = '{8'h05, 8'hFB, 8'h10, 8'hF0, 8'h80, 8'h00};
   logic       mode_ovf [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      RESETN    = 1'b0;
      FLUSH     = 1'b0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b0;
      OPSEL     = 2'b00;
      REGOUT2   = '0;
      IMMEDIATE = '0;

      // Reset state
      #12;
      check_eq("rst_valid", 32'(OUT_VALID), 32'd0);
      check_eq("rst_count", 32'(COUNT), 32'd0);
      check_eq("rst_operand", 32'(OPERAND), 32'h00);
      check_eq("rst_negovf", 32'(NEGOVF), 32'd0);
      check_eq("rst_in_ready", 32'(IN_READY), 32'd1);
      RESETN = 1'b1;
      tick();

      // Modes and negate overflow, streamed back to back
      OUT_READY = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push_one(mode_sel[i], mode_reg[i], 8'h10);
         tick();
         check_eq($sformatf("mode%0d_operand", i), 32'(OPERAND), 32'(mode_op[i]));
         check_eq($sformatf("mode%0d_negovf", i), 32'(NEGOVF), 32'(mode_ovf[i]));
         check_eq($sformatf("mode%0d_valid", i), 32'(OUT_VALID), 32'd1);
      end
      IN_VALID = 1'b0;
      tick();
      check_eq("mode_drain_count", 32'(COUNT), 32'd0);

      // Backpressure: third request refused until the head pops
      OUT_READY = 1'b0;
      push_one(2'b00, 8'hA1, 8'h00);
      check_eq("bp_rdy1", 32'(IN_READY), 32'd1);
      tick();
      push_one(2'b00, 8'hA2, 8'h00);
      check_eq("bp_rdy2", 32'(IN_READY), 32'd1);
      tick();
      push_one(2'b00, 8'hA3, 8'h00);
      check_eq("bp_rdy3", 32'(IN_READY), 32'd0);
      check_eq("bp_full_count", 32'(COUNT), 32'd2);
      check_eq("bp_head", 32'(OPERAND), 32'hA1);
      tick();
      check_eq("bp_hold_count", 32'(COUNT), 32'd2);
      check_eq("bp_hold_head", 32'(OPERAND), 32'hA1);
      OUT_READY = 1'b1;
      #1;
      check_eq("bp_rdy_full_pop", 32'(IN_READY), 32'd1);
      tick();
      IN_VALID = 1'b0;
      check_eq("bp_out2", 32'(OPERAND), 32'hA2);
      check_eq("bp_count_pushpop", 32'(COUNT), 32'd2);
      tick();
      check_eq("bp_out3", 32'(OPERAND), 32'hA3);
      check_eq("bp_count1", 32'(COUNT), 32'd1);
      tick();
      check_eq("bp_empty_valid", 32'(OUT_VALID), 32'd0);
      check_eq("bp_empty_count", 32'(COUNT), 32'd0);
      check_eq("bp_empty_not_x", 32'($isunknown(OPERAND)), 32'd0);

      // Streaming: one result per cycle, occupancy stays at 1
      for (int i = 0; i < 16; i++) begin
         push_one(2'b00, 8'(8'h20 + i), 8'h00);
         tick();
         check_eq($sformatf("stream%0d_operand", i), 32'(OPERAND), 32'(8'h20 + i));
         check_eq($sformatf("stream%0d_count", i), 32'(COUNT), 32'd1);
      end
      IN_VALID = 1'b0;
      tick();
      check_eq("stream_drain", 32'(COUNT), 32'd0);

      // Flush from full with a request present
      OUT_READY = 1'b0;
      push_one(2'b00, 8'hB1, 8'h00);
      tick();
      push_one(2'b00, 8'hB2, 8'h00);
      tick();
      check_eq("fl_full_count", 32'(COUNT), 32'd2);
      push_one(2'b00, 8'hB3, 8'h00);
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      check_eq("fl_count", 32'(COUNT), 32'd0);
      check_eq("fl_valid", 32'(OUT_VALID), 32'd0);

      // Flush with an acceptable request: it must be discarded
      push_one(2'b00, 8'hB4, 8'h00);
      tick();
      push_one(2'b00, 8'hB5, 8'h00);
      check_eq("fl2_rdy", 32'(IN_READY), 32'd1);
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      check_eq("fl2_count", 32'(COUNT), 32'd0);
      check_eq("fl2_valid", 32'(OUT_VALID), 32'd0);
      tick();
      check_eq("fl2_absent", 32'(COUNT), 32'd0);
      push_one(2'b00, 8'hB6, 8'h00);
      tick();
      IN_VALID = 1'b0;
      check_eq("fl_resume_head", 32'(OPERAND), 32'hB6);
      check_eq("fl_resume_count", 32'(COUNT), 32'd1);

      // Asynchronous reset mid-traffic
      push_one(2'b11, 8'h00, 8'h33);
      tick();
      #2;
      RESETN = 1'b0;
      #1;
      check_eq("arst_valid", 32'(OUT_VALID), 32'd0);
      check_eq("arst_count", 32'(COUNT), 32'd0);
      check_eq("arst_operand", 32'(OPERAND), 32'h00);
      IN_VALID = 1'b0;
      OUT_READY = 1'b0;
      tick();
      RESETN = 1'b1;
      #1;
      check_eq("arst_in_ready", 32'(IN_READY), 32'd1);
      tick();
      check_eq("arst_stays_empty", 32'(COUNT), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_operand_select_pipe
